uart_rx_deser_param: RTL and testbench
======================================

// Module: uart_rx_deser_param
// PURPOSE
//  Parametrised UART RX deserializer: assembles sampled serial bits into a parallel word.
//  Supports run-time frame length, selectable bit order and a one-cycle data_valid pulse.
//  Sits between the RX bit sampler (sampled_bit/bit_stb) and the RX FSM/stop-check logic.
// PARAMETERS
//  DATA_W     8   maximum data bits per frame (5..16); width of p_data
//  MSB_FIRST  0   0 = first received bit -> p_data[0]; 1 = first bit -> p_data[len-1]
// PORTS
//  clk          in   1                       clock, rising edge
//  rst          in   1                       asynchronous, active-low reset
//  sampled_bit  in   1                       majority-sampled RX bit
//  bit_stb      in   1                       1-cycle strobe: sampled_bit valid this cycle
//  deser_en     in   1                       frame window from RX FSM; low = abort/idle
//  cfg_len      in   $clog2(DATA_W+1)        data bits per frame, latched at frame start
//  par_odd      in   1                       parity type, latched at frame start (1 = odd)
//  p_data       out  DATA_W                  last completed word, held until next completion
//  data_valid   out  1                       1-cycle pulse when p_data updates
//  busy         out  1                       high in SHIFT/PARITY states
//  parity_err   out  1                       parity result of last frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: p_data=0, data_valid=0, busy=0, parity_err=0, bit counter=0, shift reg=0, state IDLE.
//  States: IDLE -> SHIFT -> [PARITY] -> DONE -> IDLE.
//  IDLE: on deser_en=1, latch len=clamp(cfg_len,5,DATA_W) and par_odd; go SHIFT, cnt=0.
//    A bit_stb in the same cycle as entry is captured as bit 0.
//  SHIFT: each bit_stb stores sampled_bit at index cnt (or len-1-cnt when MSB_FIRST), cnt++.
//    On the stb where cnt==len-1: go PARITY (if enabled) else DONE.
//  PARITY: next bit_stb captures the parity bit; go DONE.
//  DONE entry (registered): p_data <= shift reg with bits [DATA_W-1:len] forced 0;
//    data_valid=1 for exactly one cycle, i.e. the cycle after the final strobe.
//  DONE: ignore bit_stb; return to IDLE when deser_en=0. No re-arm without deser_en low.
//  Abort: deser_en=0 in SHIFT/PARITY -> IDLE next cycle; cnt and shift reg cleared;
//    p_data, parity_err unchanged; no data_valid.
//  bit_stb while deser_en=0: ignored in all states.
//  Changing cfg_len/par_odd mid-frame: no effect until the next frame start.
//  busy = (state==SHIFT || state==PARITY). Counter never exceeds len; no wrap.
// CONFIGURATION
//  Macro UART_RX_DESER_PARITY_EN:
//   defined  : PARITY state present; parity_err <= (^data ^ par_bit ^ par_odd) on the same
//              edge as data_valid; parity_err holds until the next completed frame.
//   undefined: PARITY state removed; SHIFT goes straight to DONE; parity_err tied 0;
//              par_odd is unused.
// TESTING
//  1 Reset mid-frame (3 bits in): p_data=0, busy=0, data_valid=0 immediately, async.
//  2 len=8, LSB-first, bits 1,0,1,0,0,1,0,1 -> p_data=8'hA5, one data_valid pulse 1 clk
//    after the 8th stb.
//  3 MSB_FIRST=1, len=8, same bits -> p_data=8'hA5 bit-reversed = 8'hA5 (palindrome);
//    repeat with 1,1,0,0,0,0,0,0 -> 8'hC0.
//  4 len=5, bits 1,1,1,1,1 -> p_data=8'h1F (upper bits 0); cfg_len=2 -> clamped to 5;
//    cfg_len=12 -> clamped to 8.
//  5 deser_en dropped after 4 stbs -> no data_valid, p_data retains the previous 8'hA5;
//    next full frame is correct.
//  6 PARITY_EN, len=8, data 8'h03, par_odd=0, parity bit 1 -> parity_err=1;
//    with parity bit 0 -> parity_err=0; extra stbs in DONE are ignored.

Source files
------------

// File: rtl/uart_rx_deser_param_if.sv
// uart_rx_deser_param_if: bit-sampler/RX-FSM side bundle of the UART RX deserializer
interface uart_rx_deser_param_if #(parameter int DATA_W = 8);
  localparam int LW = $clog2(DATA_W + 1);
  logic sampled_bit, bit_stb, deser_en, par_odd;
  logic [LW-1:0] cfg_len;
  logic [DATA_W-1:0] p_data;
  logic data_valid, busy, parity_err;
  modport master(output sampled_bit, bit_stb, deser_en, cfg_len, par_odd, input p_data, data_valid, busy, parity_err);
  modport slave(input sampled_bit, bit_stb, deser_en, cfg_len, par_odd, output p_data, data_valid, busy, parity_err);
endinterface

// File: rtl/uart_rx_deser_param.sv
// uart_rx_deser_param: assembles strobed UART RX bits into a parallel word; define
// UART_RX_DESER_PARITY_EN to add the parity-bit stage and parity_err.
module uart_rx_deser_param #(
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst,
  uart_rx_deser_param_if.slave s
);
  localparam int LW = $clog2(DATA_W + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3;
`ifdef UART_RX_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic [1:0] state_q, state_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, len_in, len_c, cnt_c, idx;
  logic [DATA_W-1:0] sreg_q, sreg_d, p_data_q, p_data_d, mask;
  logic par_odd_q, par_odd_d, perr_q, perr_d, dv_q, dv_d, idle, take, last, fin;
  always_comb begin
    idle = state_q == IDLE;
    len_in = s.cfg_len < LW'(5) ? LW'(5) : s.cfg_len > LW'(DATA_W) ? LW'(DATA_W) : s.cfg_len;
    // in IDLE the frame starts this cycle, so a same-cycle strobe uses the fresh length
    len_c = idle ? len_in : len_q;
    cnt_c = idle ? '0 : cnt_q;
    idx = MSB_FIRST ? len_c - cnt_c - LW'(1) : cnt_c;
    take = s.deser_en && s.bit_stb && (idle || state_q == SHIFT);
    last = take && cnt_c == len_c - LW'(1);
    fin = (last && !PAR_EN) || (s.deser_en && s.bit_stb && state_q == PARITY);
    state_d = !s.deser_en ? IDLE : idle ? SHIFT : last ? (PAR_EN ? PARITY : DONE) : fin ? DONE : state_q;
    len_d = idle ? len_in : len_q;
    par_odd_d = idle ? s.par_odd : par_odd_q;
    cnt_d = !s.deser_en ? '0 : take ? cnt_c + LW'(1) : cnt_c;
    sreg_d = (!s.deser_en || idle) ? '0 : sreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = LW'(i) < len_c;
      if (take && LW'(i) == idx) sreg_d[i] = s.sampled_bit;
    end
    p_data_d = fin ? sreg_d & mask : p_data_q;
    perr_d = (fin && PAR_EN) ? ^(sreg_d & mask) ^ s.sampled_bit ^ par_odd_q : perr_q;
    dv_d = fin;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      sreg_q <= '0;
      p_data_q <= '0;
      par_odd_q <= 1'b0;
      perr_q <= 1'b0;
      dv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      sreg_q <= sreg_d;
      p_data_q <= p_data_d;
      par_odd_q <= par_odd_d;
      perr_q <= perr_d;
      dv_q <= dv_d;
    end
  assign s.p_data = p_data_q;
  assign s.data_valid = dv_q;
  assign s.busy = state_q == SHIFT || state_q == PARITY;
  assign s.parity_err = PAR_EN & perr_q;
endmodule

// File: tb/tb_uart_rx_deser_param.sv
// tb_uart_rx_deser_param: LSB- and MSB-first deserializers driven by the same directed and
// random frames, checked each cycle against a frame-level model built from a bit queue.
`timescale 1ns/1ps
module tb_uart_rx_deser_param;
`ifdef UART_RX_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, sb = 1'b0, stb = 1'b0, en = 1'b0, par_odd = 1'b0;
  logic [3:0] cfg_len = 4'd8;
  int n_chk = 0, n_pass = 0;
  int ph = 0, flen = 8;
  bit fpar = 1'b0;
  bit q[$];
  logic [7:0] exp_p0 = 8'h00, exp_p1 = 8'h00;
  logic exp_dv = 1'b0, exp_busy = 1'b0, exp_perr = 1'b0;

  uart_rx_deser_param_if #(.DATA_W(8)) i0 ();
  uart_rx_deser_param_if #(.DATA_W(8)) i1 ();
  assign i0.sampled_bit = sb;
  assign i0.bit_stb = stb;
  assign i0.deser_en = en;
  assign i0.cfg_len = cfg_len;
  assign i0.par_odd = par_odd;
  assign i1.sampled_bit = sb;
  assign i1.bit_stb = stb;
  assign i1.deser_en = en;
  assign i1.cfg_len = cfg_len;
  assign i1.par_odd = par_odd;
  uart_rx_deser_param #(.DATA_W(8), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .s(i0));
  uart_rx_deser_param #(.DATA_W(8), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .s(i1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int clamp(input logic [3:0] c);
    return c < 4'd5 ? 5 : c > 4'd8 ? 8 : int'(c);
  endfunction

  task automatic finish(input bit pb);
    exp_p0 = 8'h00;
    exp_p1 = 8'h00;
    foreach (q[i]) begin
      exp_p0[i] = q[i];
      exp_p1[flen - 1 - i] = q[i];
    end
    if (PAR) exp_perr = ^exp_p0 ^ pb ^ fpar;
    exp_dv = 1'b1;
    ph = 3;
  endtask

  // ph: 0 idle, 1 collecting data, 2 awaiting parity bit, 3 frame complete
  task automatic model(input bit e, input bit st, input bit b);
    exp_dv = 1'b0;
    if (!e) begin
      ph = 0;
      q.delete();
    end else if (ph == 0) begin
      flen = clamp(cfg_len);
      fpar = par_odd;
      q.delete();
      ph = 1;
      if (st) q.push_back(b);
    end else if (ph == 1 && st) begin
      q.push_back(b);
      if (q.size() == flen) begin
        if (PAR) ph = 2;
        else finish(1'b0);
      end
    end else if (ph == 2 && st) finish(b);
    exp_busy = ph == 1 || ph == 2;
  endtask

  task automatic step(input bit e, input bit st, input bit b);
    en = e;
    stb = st;
    sb = b;
    @(posedge clk);
    #1;
    model(e, st, b);
  endtask

  task automatic frame(input logic [3:0] cl, input bit po, input logic [15:0] bits, input bit pb, input int abort_at);
    int n;
    int k;
    n = clamp(cl);
    k = int'($urandom_range(0, 1));
    cfg_len = cl;
    par_odd = po;
    step(1'b1, k[0], k[0] ? bits[0] : 1'($urandom));
    while (k <= n) begin
      cfg_len = 4'($urandom);
      par_odd = 1'($urandom);
      if (k == abort_at) begin
        step(1'b0, 1'($urandom), 1'b1);
        return;
      end
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'($urandom));
      step(1'b1, 1'b1, k < n ? bits[k] : pb);
      k++;
    end
    repeat (2) step(1'b1, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) if (rst) begin
    chk("p_data_lsb", i0.p_data, exp_p0);
    chk("p_data_msb", i1.p_data, exp_p1);
    chk("valid_lsb", {7'b0, i0.data_valid}, {7'b0, exp_dv});
    chk("valid_msb", {7'b0, i1.data_valid}, {7'b0, exp_dv});
    chk("busy_lsb", {7'b0, i0.busy}, {7'b0, exp_busy});
    chk("busy_msb", {7'b0, i1.busy}, {7'b0, exp_busy});
    chk("perr_lsb", {7'b0, i0.parity_err}, {7'b0, exp_perr});
    chk("perr_msb", {7'b0, i1.parity_err}, {7'b0, exp_perr});
  end

  initial begin
    #3;
    chk("rst_p_data", i0.p_data, 8'h00);
    chk("rst_valid", {7'b0, i0.data_valid}, 8'h00);
    chk("rst_busy", {7'b0, i1.busy}, 8'h00);
    #9 rst = 1'b1;
    frame(4'd8, 1'b0, 16'h00A5, 1'b0, -1);
    chk("a5_lsb", i0.p_data, 8'hA5);
    chk("a5_msb", i1.p_data, 8'hA5);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_p_data", i0.p_data, 8'h00);
    chk("async_rst_busy", {7'b0, i0.busy}, 8'h00);
    chk("async_rst_valid", {7'b0, i1.data_valid}, 8'h00);
    en = 1'b0;
    stb = 1'b0;
    ph = 0;
    q.delete();
    exp_p0 = 8'h00;
    exp_p1 = 8'h00;
    exp_dv = 1'b0;
    exp_busy = 1'b0;
    exp_perr = 1'b0;
    #4 rst = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'($urandom));
    frame(4'd8, 1'b0, 16'h00A5, 1'b0, -1);
    chk("msb_a5", i1.p_data, 8'hA5);
    frame(4'd8, 1'b0, 16'h0003, 1'b0, -1);
    chk("msb_c0", i1.p_data, 8'hC0);
    chk("lsb_03", i0.p_data, 8'h03);
    frame(4'd5, 1'b0, 16'h001F, 1'b0, -1);
    chk("len5_lsb", i0.p_data, 8'h1F);
    chk("len5_msb", i1.p_data, 8'h1F);
    frame(4'd2, 1'b0, 16'h0001, 1'b0, -1);
    chk("clamp_lo_lsb", i0.p_data, 8'h01);
    chk("clamp_lo_msb", i1.p_data, 8'h10);
    frame(4'd12, 1'b0, 16'h000F, 1'b0, -1);
    chk("clamp_hi_lsb", i0.p_data, 8'h0F);
    chk("clamp_hi_msb", i1.p_data, 8'hF0);
    frame(4'd8, 1'b0, 16'h00A5, 1'b0, -1);
    frame(4'd8, 1'b0, 16'h0003, 1'b0, 4);
    chk("abort_keep", i0.p_data, 8'hA5);
    chk("abort_busy", {7'b0, i0.busy}, 8'h00);
    frame(4'd8, 1'b0, 16'h0003, 1'b0, -1);
    chk("after_abort", i0.p_data, 8'h03);
    frame(4'd8, 1'b0, 16'h0003, 1'b1, -1);
    chk("perr_set", {7'b0, i0.parity_err}, {7'b0, PAR});
    frame(4'd8, 1'b0, 16'h0003, 1'b0, -1);
    chk("perr_clr", {7'b0, i1.parity_err}, 8'h00);
    chk("perr_data", i0.p_data, 8'h03);
    repeat (60) begin
      logic [3:0] cl;
      cl = 4'($urandom);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
      frame(cl, 1'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0 ? int'($urandom_range(1, clamp(cl))) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
